// File: rtl/fifo_stream_reader.sv
// Drain side of a synchronous FIFO: issues reads into a 2-entry skid buffer and
// presents the words on a valid/ready stream master at up to one word per clock.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  words_sent,
    output logic                  busy
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic [CNT_WIDTH-1:0]  words_sent_q, words_sent_d;

    logic                  pop;
    logic [2:0]            load;

    // load is the occupancy after this edge, before any new read lands.
    always_comb begin
        m_valid          = (occ_q != 2'd0);
        m_data           = buf_q[head_q];
        pop              = m_valid & m_ready;
        load             = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_read_enable = enable & ~fifo_empty & ~reset & (load < 3'd2);
        busy             = m_valid | inflight_q;
        words_sent       = words_sent_q;
    end

    always_comb begin
        occ_d        = load[1:0];
        inflight_d   = fifo_read_enable;
        head_d       = head_q;
        tail_d       = tail_q;
        buf_d        = buf_q;
        words_sent_d = words_sent_q;

        // The issue rule guarantees a free slot, so capture never checks occupancy.
        if (inflight_q) begin
            buf_d[tail_q] = fifo_data_out;
            tail_d        = ~tail_q;
        end

        if (pop) begin
            head_d = ~head_q;
            if (words_sent_q != {CNT_WIDTH{1'b1}}) begin
                words_sent_d = words_sent_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            head_q       <= 1'b0;
            tail_q       <= 1'b0;
            buf_q[0]     <= '0;
            buf_q[1]     <= '0;
            words_sent_q <= '0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            buf_q[0]     <= buf_d[0];
            buf_q[1]     <= buf_d[1];
            words_sent_q <= words_sent_d;
        end
    end

`ifndef SYNTHESIS
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

    a_no_retract: assert property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

    a_no_empty_read: assert property (@(posedge clk) disable iff (reset)
        fifo_read_enable |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader, checked against a
// word-index model of the FIFO -> buffer -> stream path.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        m_ready = 1'b0;
    logic        fifo_empty;
    logic        fifo_read_enable, m_valid, busy;
    logic        rd4, mv4, busy4;
    logic [7:0]  fifo_data_out = 8'h00;
    logic [7:0]  m_data, md4;
    logic [15:0] words_sent;
    logic [3:0]  ws4;

    // All words ever pushed; FIFO and model both walk this by index.
    logic [7:0]  src_all [0:1023];
    int          n_pushed = 0;
    int          n_fifo_rd = 0;
    int          n_iss = 0, n_cap = 0, n_pop = 0, sent_m = 0;
    int          checks = 0, errors = 0;

    int          occ_m, infl_m;
    logic        exp_mv, exp_pop, exp_rd, exp_busy;
    logic [7:0]  exp_data;
    logic [15:0] exp_ws;
    logic [3:0]  exp_ws4;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_enable(fifo_read_enable), .fifo_data_out(fifo_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .words_sent(words_sent), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_enable(rd4), .fifo_data_out(fifo_data_out),
        .m_data(md4), .m_valid(mv4), .m_ready(m_ready),
        .words_sent(ws4), .busy(busy4)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (n_fifo_rd == n_pushed);

    // Behavioural FIFO: registered read data, pointer advances on every strobe.
    always @(posedge clk) begin
        if (fifo_read_enable) begin
            fifo_data_out <= src_all[n_fifo_rd];
            n_fifo_rd     <= n_fifo_rd + 1;
        end
    end

    always_comb begin
        occ_m    = n_cap - n_pop;
        infl_m   = n_iss - n_cap;
        exp_mv   = (occ_m != 0);
        exp_pop  = exp_mv & m_ready;
        exp_rd   = enable & ~fifo_empty & ~reset & ((occ_m + infl_m - (exp_pop ? 1 : 0)) < 2);
        exp_busy = (occ_m != 0) || (infl_m != 0);
        exp_data = exp_mv ? src_all[n_pop] : 8'h00;
        exp_ws   = (sent_m > 65535) ? 16'hFFFF : sent_m[15:0];
        exp_ws4  = (sent_m > 15) ? 4'hF : sent_m[3:0];
    end

    // Model: reads issued, words captured, words popped (all as word indices).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_cap  <= n_iss;
            n_pop  <= n_iss;
            sent_m <= 0;
        end else begin
            if (exp_rd) n_iss <= n_iss + 1;
            n_cap <= n_iss;
            if (exp_pop) begin
                n_pop  <= n_pop + 1;
                sent_m <= sent_m + 1;
            end
        end
    end

    task automatic tick(input logic en, input logic rdy);
        @(negedge clk);
        enable  = en;
        m_ready = rdy;
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        src_all[n_pushed] = w;
        n_pushed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(1'b1, 1'b1);
        push(8'h5A);
        #1;
        checks++;
        if (fifo_read_enable !== 1'b0 || rd4 !== 1'b0) begin
            errors++; $display("FAIL reset_rd got=%b want=0", fifo_read_enable);
        end
        checks++;
        if (m_valid !== 1'b0 || mv4 !== 1'b0) begin
            errors++; $display("FAIL reset_valid got=%b want=0", m_valid);
        end
        checks++;
        if (m_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%h want=00", m_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (words_sent !== 16'd0 || ws4 !== 4'd0) begin
            errors++; $display("FAIL reset_count got=%0d want=0", words_sent);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || ws4 !== exp_ws4 ||
                {rd4, mv4, busy4} !== {exp_rd, exp_mv, exp_busy} ||
                (exp_mv && (m_data !== exp_data || md4 !== exp_data))) begin
                errors++;
                $display("FAIL reset_drain cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b ws=%0d want %0d",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data,
                         busy, exp_busy, words_sent, exp_ws);
            end
        end
        checks++;
        if (words_sent !== 16'd1) begin
            errors++; $display("FAIL reset_first_word got=%0d want=1", words_sent);
        end
    endtask

    task automatic test_stream();
        int rd_cnt = 0, val_cnt = 0, first_rd = -1, first_val = -1;
        logic [15:0] ws0;
        tick(1'b0, 1'b1);
        ws0 = words_sent;
        push(8'h11); push(8'h22); push(8'h33);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || ws4 !== exp_ws4 ||
                {rd4, mv4, busy4} !== {exp_rd, exp_mv, exp_busy} ||
                (exp_mv && (m_data !== exp_data || md4 !== exp_data))) begin
                errors++;
                $display("FAIL stream cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b ws=%0d want %0d",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data,
                         busy, exp_busy, words_sent, exp_ws);
            end
            if (fifo_read_enable === 1'b1) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = i;
            end
            if (m_valid === 1'b1) begin
                val_cnt++;
                if (first_val < 0) first_val = i;
            end
        end
        checks++;
        if (rd_cnt != 3 || val_cnt != 3) begin
            errors++; $display("FAIL stream_counts reads=%0d valids=%0d want 3/3", rd_cnt, val_cnt);
        end
        checks++;
        if (first_rd < 0 || first_val - first_rd != 2) begin
            errors++; $display("FAIL stream_latency got=%0d want=2", first_val - first_rd);
        end
        checks++;
        if (busy !== 1'b0 || words_sent - ws0 !== 16'd3) begin
            errors++; $display("FAIL stream_end busy=%b sent=%0d want 0/3", busy, words_sent - ws0);
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0, first_val = -1, last_val = -1;
        logic [15:0] ws0;
        tick(1'b0, 1'b0);
        ws0 = words_sent;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, busy, exp_busy);
            end
            if (fifo_read_enable === 1'b1) rd_cnt++;
        end
        checks++;
        if (rd_cnt != 2 || fifo_read_enable !== 1'b0) begin
            errors++; $display("FAIL bp_reads got=%0d want=2", rd_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL bp_release cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, busy, exp_busy);
            end
            if (m_valid === 1'b1) begin
                if (first_val < 0) first_val = i;
                last_val = i;
            end
        end
        checks++;
        if (words_sent - ws0 !== 16'd4 || last_val - first_val != 3) begin
            errors++;
            $display("FAIL bp_drain sent=%0d span=%0d want 4/4", words_sent - ws0, last_val - first_val + 1);
        end
    endtask

    task automatic test_toggle();
        logic        hold;
        logic [7:0]  held;
        logic [15:0] ws0;
        tick(1'b0, 1'b0);
        ws0 = words_sent;
        for (int i = 0; i < 8; i++) push(8'h80 + 8'(i * 3));
        for (int i = 0; i < 24; i++) begin
            hold = m_valid & ~m_ready;
            held = m_data;
            tick(1'b1, (i % 2) == 0);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL toggle cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, busy, exp_busy);
            end
            if (hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL toggle_stable cyc=%0d valid=%b data=%h want 1/%h", i, m_valid, m_data, held);
                end
            end
        end
        checks++;
        if (words_sent - ws0 !== 16'd8) begin
            errors++; $display("FAIL toggle_sent got=%0d want=8", words_sent - ws0);
        end
    endtask

    task automatic test_enable_drop();
        int rd_cnt = 0;
        logic [15:0] ws0;
        tick(1'b0, 1'b1);
        ws0 = words_sent;
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        tick(1'b1, 1'b1);
        checks++;
        if (fifo_read_enable !== 1'b1) begin
            errors++; $display("FAIL en_strobe got=%b want=1", fifo_read_enable);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL en_off cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, busy, exp_busy);
            end
            if (fifo_read_enable === 1'b1) rd_cnt++;
        end
        checks++;
        if (rd_cnt != 0 || words_sent - ws0 !== 16'd1 || n_pushed - n_fifo_rd != 3) begin
            errors++;
            $display("FAIL en_off_result reads=%0d sent=%0d left=%0d want 0/1/3",
                     rd_cnt, words_sent - ws0, n_pushed - n_fifo_rd);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL en_on cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, busy, exp_busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int         base;
        logic       got_first = 1'b0;
        logic [7:0] first_data = 8'h00;
        tick(1'b0, 1'b0);
        base = n_pushed;
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL rmid_fill cyc=%0d rd=%b want %b valid=%b want %b busy=%b want %b",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, busy, exp_busy);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || words_sent !== 16'd0 || ws4 !== 4'd0 ||
            fifo_read_enable !== 1'b0 || n_fifo_rd - base != 2) begin
            errors++;
            $display("FAIL rmid_async valid=%b busy=%b ws=%0d rd=%b reads=%0d want 0/0/0/0/2",
                     m_valid, busy, words_sent, fifo_read_enable, n_fifo_rd - base);
        end
        tick(1'b1, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || ws4 !== exp_ws4 || (exp_mv && m_data !== exp_data)) begin
                errors++;
                $display("FAIL rmid_resume cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h ws=%0d want %0d",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data, words_sent, exp_ws);
            end
            if (m_valid === 1'b1 && !got_first) begin
                got_first  = 1'b1;
                first_data = m_data;
            end
        end
        checks++;
        if (!got_first || first_data !== 8'hC2) begin
            errors++; $display("FAIL rmid_first got=%h want=c2", first_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
            checks++;
            if (fifo_read_enable !== exp_rd || m_valid !== exp_mv || busy !== exp_busy ||
                words_sent !== exp_ws || ws4 !== exp_ws4 ||
                {rd4, mv4, busy4} !== {exp_rd, exp_mv, exp_busy} ||
                (exp_mv && (m_data !== exp_data || md4 !== exp_data))) begin
                errors++;
                $display("FAIL random cyc=%0d rd=%b want %b valid=%b want %b data=%h want %h busy=%b want %b ws=%0d want %0d ws4=%0d want %0d",
                         i, fifo_read_enable, exp_rd, m_valid, exp_mv, m_data, exp_data,
                         busy, exp_busy, words_sent, exp_ws, ws4, exp_ws4);
            end
            if (i < 360 && $urandom_range(0, 1) == 1) push(8'($urandom));
        end
        checks++;
        if (sent_m < 20 || ws4 !== 4'hF) begin
            errors++; $display("FAIL saturate ws4=%0d want=15 (transfers=%0d)", ws4, sent_m);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_enable_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
